// File: rtl/umips_hazard_if.sv
// Pipeline-to-hazard-unit bundle: decode/execute/memory/writeback status in,
// stall, flush and forwarding controls out.
interface umips_hazard_if;
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic       uses_rs_d;
    logic       uses_rt_d;
    logic       branch_d;
    logic       pc_src_d;
    logic       hilo_read_d;
    logic       md_op_d;

    logic [4:0] rs_e;
    logic [4:0] rt_e;
    logic [4:0] write_reg_e;
    logic       reg_write_e;
    logic       mem_to_reg_e;
    logic       md_start_e;
    logic       md_div_e;

    logic [4:0] write_reg_m;
    logic       reg_write_m;
    logic       mem_to_reg_m;
    logic [4:0] write_reg_w;
    logic       reg_write_w;
    logic       imem_ready;
    logic       dmem_ready;

    logic       stall_f;
    logic       stall_d;
    logic       stall_e;
    logic       stall_m;
    logic       flush_d;
    logic       flush_e;
    logic [1:0] fwd_a_e;
    logic [1:0] fwd_b_e;
    logic       fwd_a_d;
    logic       fwd_b_d;
    logic       md_busy;

    modport master (
        output rs_d, rt_d, uses_rs_d, uses_rt_d, branch_d, pc_src_d, hilo_read_d, md_op_d,
        output rs_e, rt_e, write_reg_e, reg_write_e, mem_to_reg_e, md_start_e, md_div_e,
        output write_reg_m, reg_write_m, mem_to_reg_m, write_reg_w, reg_write_w,
        output imem_ready, dmem_ready,
        input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
        input  fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, md_busy
    );

    modport slave (
        input  rs_d, rt_d, uses_rs_d, uses_rt_d, branch_d, pc_src_d, hilo_read_d, md_op_d,
        input  rs_e, rt_e, write_reg_e, reg_write_e, mem_to_reg_e, md_start_e, md_div_e,
        input  write_reg_m, reg_write_m, mem_to_reg_m, write_reg_w, reg_write_w,
        input  imem_ready, dmem_ready,
        output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
        output fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, md_busy
    );
endinterface

// File: rtl/umips_hazard.sv
// Five-stage MIPS hazard unit: operand forwarding, load-use/branch/HI-LO
// interlocks, redirect and memory-wait stalls, plus the mult/div busy timer.
module umips_hazard #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input logic           clk,
    input logic           rst,
    umips_hazard_if.slave hz
);

    logic [5:0] md_cnt_q;
    logic [5:0] md_cnt_d;
    logic       md_busy;
    logic       lw_stall;
    logic       br_stall;
    logic       md_stall;
    logic       data_stall;
    logic       mem_stall;
    logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic       fwd_a_d, fwd_b_d;

    function automatic logic match(input logic rw, input logic [4:0] wr, input logic [4:0] src);
        return rw && (wr != 5'd0) && (wr == src);
    endfunction

    assign md_busy = (md_cnt_q != 6'd0);

    always_comb begin
        lw_stall   = 1'b0;
        br_stall   = 1'b0;
        md_stall   = 1'b0;
        data_stall = 1'b0;
        mem_stall  = 1'b0;
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        stall_e    = 1'b0;
        stall_m    = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        fwd_a_e    = 2'b00;
        fwd_b_e    = 2'b00;
        fwd_a_d    = 1'b0;
        fwd_b_d    = 1'b0;

        if (match(hz.reg_write_m, hz.write_reg_m, hz.rs_e))      fwd_a_e = 2'b10;
        else if (match(hz.reg_write_w, hz.write_reg_w, hz.rs_e)) fwd_a_e = 2'b01;
        if (match(hz.reg_write_m, hz.write_reg_m, hz.rt_e))      fwd_b_e = 2'b10;
        else if (match(hz.reg_write_w, hz.write_reg_w, hz.rt_e)) fwd_b_e = 2'b01;

        // A load result in M is not available yet, so decode-stage forwarding excludes it.
        fwd_a_d = match(hz.reg_write_m, hz.write_reg_m, hz.rs_d) && !hz.mem_to_reg_m;
        fwd_b_d = match(hz.reg_write_m, hz.write_reg_m, hz.rt_d) && !hz.mem_to_reg_m;

        lw_stall = hz.mem_to_reg_e &&
                   ((hz.uses_rs_d && match(hz.reg_write_e, hz.write_reg_e, hz.rs_d)) ||
                    (hz.uses_rt_d && match(hz.reg_write_e, hz.write_reg_e, hz.rt_d)));
        br_stall = hz.branch_d &&
                   (match(hz.reg_write_e, hz.write_reg_e, hz.rs_d) ||
                    match(hz.reg_write_e, hz.write_reg_e, hz.rt_d) ||
                    (hz.mem_to_reg_m &&
                     (match(hz.reg_write_m, hz.write_reg_m, hz.rs_d) ||
                      match(hz.reg_write_m, hz.write_reg_m, hz.rt_d))));
        md_stall   = md_busy && (hz.hilo_read_d || hz.md_op_d);
        data_stall = lw_stall || br_stall || md_stall;
        mem_stall  = !hz.dmem_ready;

        // Redirects are dropped while decode is held; they resurface once the hold clears.
        if (mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
        end else if (data_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end else begin
            stall_f = !hz.imem_ready;
            flush_d = hz.pc_src_d || !hz.imem_ready;
        end
    end

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (hz.md_start_e && !stall_e)
            md_cnt_d = hz.md_div_e ? 6'(DIV_CYCLES) : 6'(MULT_CYCLES);
        else if (md_cnt_q != 6'd0)
            md_cnt_d = md_cnt_q - 6'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) md_cnt_q <= 6'd0;
        else      md_cnt_q <= md_cnt_d;
    end

    assign hz.stall_f = rst && stall_f;
    assign hz.stall_d = rst && stall_d;
    assign hz.stall_e = rst && stall_e;
    assign hz.stall_m = rst && stall_m;
    assign hz.flush_d = rst && flush_d;
    assign hz.flush_e = rst && flush_e;
    assign hz.fwd_a_e = rst ? fwd_a_e : 2'b00;
    assign hz.fwd_b_e = rst ? fwd_b_e : 2'b00;
    assign hz.fwd_a_d = rst && fwd_a_d;
    assign hz.fwd_b_d = rst && fwd_b_d;
    assign hz.md_busy = md_busy;

endmodule

// File: tb/tb_umips_hazard.sv
// Directed checks of umips_hazard: forwarding, interlocks, redirect/miss
// handling, memory wait priority, mult/div busy window and reset behaviour.
module tb_umips_hazard;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   busy_cyc;
    int   stall_cyc;
    int   mism;

    always #5 clk = ~clk;

    umips_hazard_if hz ();
    umips_hazard #(.MULT_CYCLES(4), .DIV_CYCLES(32)) dut (.clk(clk), .rst(rst), .hz(hz.slave));

    // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e}
    function automatic logic [5:0] ctl();
        return {hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m, hz.flush_d, hz.flush_e};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz.rs_d = 5'd0; hz.rt_d = 5'd0; hz.uses_rs_d = 1'b0; hz.uses_rt_d = 1'b0;
        hz.branch_d = 1'b0; hz.pc_src_d = 1'b0; hz.hilo_read_d = 1'b0; hz.md_op_d = 1'b0;
        hz.rs_e = 5'd0; hz.rt_e = 5'd0; hz.write_reg_e = 5'd0; hz.reg_write_e = 1'b0;
        hz.mem_to_reg_e = 1'b0; hz.md_start_e = 1'b0; hz.md_div_e = 1'b0;
        hz.write_reg_m = 5'd0; hz.reg_write_m = 1'b0; hz.mem_to_reg_m = 1'b0;
        hz.write_reg_w = 5'd0; hz.reg_write_w = 1'b0;
        hz.imem_ready = 1'b1; hz.dmem_ready = 1'b1;
    endtask

    initial begin
        // Reset with hazard-provoking inputs: everything must read zero.
        idle();
        hz.reg_write_m = 1'b1; hz.write_reg_m = 5'd3; hz.rs_e = 5'd3; hz.rs_d = 5'd3;
        hz.dmem_ready = 1'b0; hz.pc_src_d = 1'b1;
        #12;
        chk("reset_ctl", 32'(ctl()), 32'h0);
        chk("reset_fwd", {26'd0, hz.fwd_a_e, hz.fwd_b_e, hz.fwd_a_d, hz.fwd_b_d}, 32'h0);
        chk("reset_busy", 32'(hz.md_busy), 32'h0);
        rst = 1'b1;
        idle();
        tick();
        chk("idle_ctl", 32'(ctl()), 32'h0);

        // E-stage forwarding priority
        hz.reg_write_m = 1'b1; hz.write_reg_m = 5'd3;
        hz.reg_write_w = 1'b1; hz.write_reg_w = 5'd3; hz.rs_e = 5'd3;
        #1 chk("fwd_a_m_over_w", 32'(hz.fwd_a_e), 32'h2);
        hz.write_reg_m = 5'd0;
        #1 chk("fwd_a_w_only", 32'(hz.fwd_a_e), 32'h1);
        hz.reg_write_w = 1'b0;
        #1 chk("fwd_a_none", 32'(hz.fwd_a_e), 32'h0);
        hz.rt_e = 5'd7; hz.reg_write_w = 1'b1; hz.write_reg_w = 5'd7;
        #1 chk("fwd_b_w", 32'(hz.fwd_b_e), 32'h1);
        hz.reg_write_w = 1'b0; hz.write_reg_w = 5'd0; hz.rt_e = 5'd0; hz.write_reg_m = 5'd0;
        hz.reg_write_e = 1'b1; hz.write_reg_e = 5'd0; hz.mem_to_reg_e = 1'b1;
        hz.uses_rs_d = 1'b1; hz.rs_d = 5'd0;
        #1 chk("r0_never_matches", 32'(ctl()), 32'h0);
        idle();

        // Decode forwarding from M, and branch on a load in M
        hz.reg_write_m = 1'b1; hz.write_reg_m = 5'd4; hz.rs_d = 5'd4; hz.rt_d = 5'd4;
        #1 chk("fwd_d_alu", {30'd0, hz.fwd_a_d, hz.fwd_b_d}, 32'h3);
        hz.mem_to_reg_m = 1'b1;
        #1 chk("fwd_d_load", {30'd0, hz.fwd_a_d, hz.fwd_b_d}, 32'h0);
        hz.branch_d = 1'b1;
        #1 chk("br_stall_m_load", 32'(ctl()), 32'b110001);
        idle();

        // Branch against an E-stage producer
        hz.branch_d = 1'b1; hz.reg_write_e = 1'b1; hz.write_reg_e = 5'd9; hz.rt_d = 5'd9;
        #1 chk("br_stall_e", 32'(ctl()), 32'b110001);
        idle();

        // Load-use
        hz.mem_to_reg_e = 1'b1; hz.reg_write_e = 1'b1; hz.write_reg_e = 5'd5;
        hz.rs_d = 5'd5; hz.uses_rs_d = 1'b1;
        #1 chk("load_use", 32'(ctl()), 32'b110001);
        hz.pc_src_d = 1'b1;
        #1 chk("redirect_held", 32'(ctl()), 32'b110001);
        hz.dmem_ready = 1'b0;
        #1 chk("dmem_wait_priority", 32'(ctl()), 32'b111100);
        hz.uses_rs_d = 1'b0;
        hz.dmem_ready = 1'b1;
        #1 chk("unused_src_no_stall", 32'(ctl()), 32'b000010);
        idle();

        // Redirect and fetch miss
        hz.pc_src_d = 1'b1;
        #1 chk("redirect", 32'(ctl()), 32'b000010);
        hz.pc_src_d = 1'b0; hz.imem_ready = 1'b0;
        #1 chk("imem_miss", 32'(ctl()), 32'b100010);
        idle();

        // Divide busy window with a HI/LO read waiting in decode
        tick();
        hz.md_start_e = 1'b1; hz.md_div_e = 1'b1;
        tick();
        hz.md_start_e = 1'b0; hz.md_div_e = 1'b0; hz.hilo_read_d = 1'b1;
        busy_cyc = 0; stall_cyc = 0; mism = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (hz.md_busy === 1'b1) busy_cyc++;
            if (hz.stall_d === 1'b1) stall_cyc++;
            if (hz.stall_d !== hz.md_busy) mism++;
            tick();
        end
        chk("div_busy_cycles", 32'(busy_cyc), 32'd32);
        chk("div_stall_cycles", 32'(stall_cyc), 32'd32);
        chk("div_stall_tracks_busy", 32'(mism), 32'd0);
        idle();

        // Multiply: four busy cycles, mult/div in decode interlocks
        hz.md_start_e = 1'b1;
        tick();
        hz.md_start_e = 1'b0; hz.md_op_d = 1'b1;
        busy_cyc = 0;
        for (int i = 0; i < 10; i++) begin
            if (hz.md_busy === 1'b1) busy_cyc++;
            if (i == 0) begin
                #1 chk("md_op_stall", 32'(ctl()), 32'b110001);
            end
            tick();
        end
        chk("mult_busy_cycles", 32'(busy_cyc), 32'd4);
        idle();

        // A start held in E by a memory wait does not launch
        hz.md_start_e = 1'b1; hz.dmem_ready = 1'b0;
        tick();
        chk("start_blocked_by_stall_e", 32'(hz.md_busy), 32'h0);
        hz.md_start_e = 1'b0;
        idle();

        // Reset mid-divide at counter = 10
        hz.md_start_e = 1'b1; hz.md_div_e = 1'b1;
        tick();
        hz.md_start_e = 1'b0; hz.md_div_e = 1'b0;
        for (int i = 0; i < 22; i++) tick();
        chk("busy_before_reset", 32'(hz.md_busy), 32'h1);
        hz.hilo_read_d = 1'b1; hz.pc_src_d = 1'b1;
        hz.reg_write_w = 1'b1; hz.write_reg_w = 5'd6; hz.rs_e = 5'd6;
        #1 rst = 1'b0;
        #1;
        chk("midreset_busy", 32'(hz.md_busy), 32'h0);
        chk("midreset_ctl", 32'(ctl()), 32'h0);
        chk("midreset_fwd", {28'd0, hz.fwd_a_e, hz.fwd_b_e}, 32'h0);
        #3 rst = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("post_reset_busy", 32'(hz.md_busy), 32'h0);
        chk("post_reset_no_stall", 32'(hz.stall_d), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
